chaotic_bitgen: RTL and testbench
=================================

# chaotic_bitgen

Parametrised chaotic bit generator, successor to the fixed 16-bit logistic-map single-bit source. It iterates a W-bit fixed-point chaotic map, either logistic with r=4 or tent, at one step per clock. It packs the resulting bits into OUT_W-bit words behind a valid/ready handshake, and supports runtime seeding and automatic reseed on degenerate orbits. It feeds the keystream/LFSR-mixing stage downstream.

## Interface
Parameters:
- W, 16: state width. Fixed point with W-1 fraction bits; ONE = 2^(W-1)-1 represents 1.0.
- OUT_W, 8: output word width (1..32).
- SEED, 2^(W-2): reset/default state value (0.5).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  iteration enable.
- mode  in  1  0 = logistic (r=4), 1 = tent map; sampled every cycle.
- seed_load  in  1  one-cycle strobe, loads `seed`.
- seed  in  W  new state value.
- out_data  out  OUT_W  packed word, first-generated bit in MSB.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts word.
- x_state  out  W  current map state (debug).
- reseed_cnt  out  8  saturating count of automatic reseeds.

## Operation
Arithmetic (unsigned, 2W-bit intermediate, all truncation by dropping bits):
- Logistic: p = x*(ONE-x) (2W bits); x_next = (p<<2)[2W-2:W-1].
- Tent: if x < 2^(W-2), x_next = x<<1; otherwise x_next = (ONE-x)<<1. Both are truncated to W bits.
- Generated bit b = x_next[W-2] (threshold 0.5).

Degeneracy guard:
- If an iteration yields x_next == 0 or x_next == x, then x loads SEED instead of x_next and reseed_cnt increments, saturating at 255.
- b is still the bit taken from the computed x_next.

Packing:
- A shift register and a bit counter bc (0..OUT_W) collect bits.
- While bc == OUT_W, out_valid=1, out_data holds the word, and iteration stalls.

States:
- IDLE (en=0): x held, no bits produced.
- RUN (en=1, bc<OUT_W): one iteration per cycle, bit shifted in, bc+1.
- FULL (bc==OUT_W): out_valid=1 and x held.
  - If out_ready=1 and en=1 in the same cycle, the word transfers and an iteration occurs. bc becomes 1, which gives zero bubble.
  - If out_ready=1 and en=0, bc becomes 0.
- Leaving en low never discards a partial word.

seed_load has highest priority:
- x takes `seed`, or SEED if seed==0 or seed>ONE.
- bc is cleared, out_valid drops, and any pending or partial word is discarded.
- No iteration or transfer happens that cycle, even if out_ready=1.
- reseed_cnt is unchanged.

A mode change takes effect on the next iteration. Partial words may mix maps.

## Timing
Reset (rst=0), asynchronous:
- x=SEED, bc=0, out_data=0, out_valid=0, reseed_cnt=0.
- Deassertion is synchronised externally. The first iteration occurs on the first rising edge with rst=1 and en=1.

Latency and throughput:
- With en held high, out_valid rises OUT_W cycles after the first enabled edge.
- Sustained throughput with out_ready=1 is one word per OUT_W cycles.
- out_valid/out_data are registered and stable until the handshake completes.

Other timing rules:
- x_state updates on the same edge as the shift-in.
- reseed_cnt updates on the same edge as the guard triggers.

## Test plan
- Reset and logistic sequence: W=16, en=1, mode=0.
  - Required sequence: x_state = 0x4000 → 0x7FFE → 0x0003 → 0x000B → 0x002B.
  - Bits are 1,0,0,0.
- Packing and backpressure: OUT_W=8, out_ready=0.
  - out_valid rises after 8 enabled cycles; x_state and out_data then stay frozen for 20 cycles.
  - Raising out_ready transfers in 1 cycle, and the next word appears 8 cycles later, not 9.
- Fixed-point guard: seed_load with seed=0x5FFF, mode=0.
  - The next iteration computes 0x5FFF, so x_state becomes 0x4000 and reseed_cnt=1.
  - Repeating 300 times saturates reseed_cnt at 255.
- Tent map: mode=1, seed=0x2000.
  - Required sequence: x_state = 0x4000 → 0x7FFE → 0x0002.
  - seed=0x4000 gives 0x7FFE.
- Seed priority: seed_load asserted with out_valid=1 and out_ready=1.
  - No transfer occurs; out_valid=0 next cycle; x_state=seed.
  - seed=0x0000 or 0xFFFF loads 0x4000.
- Async reset mid-word: drop rst at bc=5.
  - Outputs go to reset values without a clock edge.
  - After release, the first word matches the reset-sequence word bit-for-bit.

Source files
------------

// File: rtl/chaotic_bitgen.sv
// Chaotic bit generator: a W-bit fixed-point logistic (r=4) or tent map stepped once per clock.
// Each step yields one bit (x_next >= 0.5); bits are packed MSB-first into OUT_W-bit words.
module chaotic_bitgen #(
  parameter int unsigned  W     = 16,
  parameter int unsigned  OUT_W = 8,
  parameter logic [W-1:0] SEED  = {2'b01, {(W-2){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [W-1:0]     seed,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     x_state,
  output logic [7:0]       reseed_cnt
);

  // state | meaning
  // IDLE  | en=0 and word not full: x held, no bits produced
  // RUN   | en=1 and word not full: one map step, bit shifted in
  // FULL  | word complete: out_valid high, x held until handshake
  typedef enum logic [1:0] {IDLE, RUN, FULL} phase_t;

  localparam int unsigned    BCW     = $clog2(OUT_W + 1);
  localparam logic [W-1:0]   ONE     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   HALF    = {2'b01, {(W-2){1'b0}}};
  localparam logic [BCW-1:0] BC_FULL = BCW'(OUT_W);

  logic [W-1:0]     x_q, x_n;
  logic [BCW-1:0]   bc_q, bc_n;
  logic [OUT_W-1:0] sr_q, sr_n;
  logic             valid_q, valid_n;
  logic [7:0]       cnt_q, cnt_n;

  logic [2*W-1:0]   prod;
  logic [W-1:0]     one_minus, x_log, x_tent, x_next, x_seed;
  logic             bit_new, degenerate, step;
  phase_t           phase;

  // (p<<2)[2W-2:W-1] is the same bit field as p[2W-4:W-3]
  always_comb begin
    one_minus  = ONE - x_q;
    prod       = {{W{1'b0}}, x_q} * {{W{1'b0}}, one_minus};
    x_log      = W'(prod >> (W - 3));
    x_tent     = (x_q < HALF) ? (x_q << 1) : (one_minus << 1);
    x_next     = mode ? x_tent : x_log;
    bit_new    = x_next[W-2];
    degenerate = (x_next == '0) || (x_next == x_q);
    x_seed     = ((seed == '0) || (seed > ONE)) ? SEED : seed;
  end

  always_comb begin
    phase = IDLE;
    if (bc_q == BC_FULL) phase = FULL;
    else if (en)         phase = RUN;

    step = 1'b0;
    bc_n = bc_q;
    if (!seed_load) begin
      unique case (phase)
        RUN: begin
          step = 1'b1;
          bc_n = bc_q + 1'b1;
        end
        FULL: begin
          if (out_ready) begin
            step = en;
            bc_n = en ? BCW'(1) : '0;
          end
        end
        default: ;
      endcase
    end else begin
      bc_n = '0;
    end

    x_n   = x_q;
    sr_n  = sr_q;
    cnt_n = cnt_q;
    if (seed_load) begin
      x_n  = x_seed;
      sr_n = '0;
    end else if (step) begin
      sr_n = OUT_W'({sr_q, bit_new});
      if (degenerate) begin
        x_n = SEED;
        if (cnt_q != 8'hFF) cnt_n = cnt_q + 8'd1;
      end else begin
        x_n = x_next;
      end
    end

    valid_n = (bc_n == BC_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= SEED;
      bc_q    <= '0;
      sr_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      x_q     <= x_n;
      bc_q    <= bc_n;
      sr_q    <= sr_n;
      valid_q <= valid_n;
      cnt_q   <= cnt_n;
    end
  end

  assign out_data   = sr_q;
  assign out_valid  = valid_q;
  assign x_state    = x_q;
  assign reseed_cnt = cnt_q;

endmodule

// File: tb/tb_chaotic_bitgen.sv
// Bench for chaotic_bitgen: a bit-queue reference model checked every cycle, plus
// directed literal expectations for the map sequences, packing, guard and seeding.
module tb_chaotic_bitgen;
  localparam int OUT_W = 8;
  localparam longint unsigned ONE_L  = 64'd32767;
  localparam longint unsigned HALF_L = 64'd16384;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic        seed_load = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [15:0] x_state;
  logic [7:0]  reseed_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  longint unsigned mx = HALF_L;
  int unsigned     mcnt = 0;
  bit              mq[$];

  chaotic_bitgen #(.W(16), .OUT_W(OUT_W), .SEED(16'h4000)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .seed_load(seed_load), .seed(seed),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .x_state(x_state), .reseed_cnt(reseed_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Real-valued map on the 1.0 = 32767 scale, floor division for truncation.
  function automatic longint unsigned step_map(input longint unsigned x, input bit m);
    longint unsigned p;
    if (!m) begin
      p = x * (ONE_L - x);
      return (4 * p) / 64'd32768;
    end
    if (x < HALF_L) return 2 * x;
    return 2 * (ONE_L - x);
  endfunction

  function automatic logic [7:0] pack_word();
    logic [7:0] w;
    w = '0;
    foreach (mq[i]) w = {w[6:0], mq[i]};
    return w;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mx = HALF_L;
        mcnt = 0;
        mq.delete();
      end else if (seed_load) begin
        mx = (seed == 16'h0 || longint'(seed) > ONE_L) ? HALF_L : longint'(seed);
        mq.delete();
      end else begin
        longint unsigned nx;
        if (mq.size() == OUT_W && out_ready) mq.delete();
        if (en && mq.size() < OUT_W) begin
          nx = step_map(mx, mode);
          mq.push_back(nx >= HALF_L);
          if (nx == 0 || nx == mx) begin
            mx = HALF_L;
            if (mcnt < 255) mcnt++;
          end else begin
            mx = nx;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_x", x_state, mx);
      check("model_valid", out_valid, mq.size() == OUT_W);
      check("model_cnt", reseed_cnt, mcnt);
      if (mq.size() == OUT_W) check("model_data", out_data, pack_word());
    end
  end

  task automatic wait_valid(input string name, input int exp_k);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    check(name, k, exp_k);
  endtask

  logic [15:0] seed_tab [5] = '{16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 16'h8000};
  logic [15:0] load_tab [5] = '{16'h1234, 16'h4000, 16'h1234, 16'h4000, 16'h4000};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_x", x_state, 16'h4000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_cnt", reseed_cnt, 8'h00);

    rst = 1'b1; en = 1'b1; mode = 1'b0; out_ready = 1'b0;
    @(negedge clk); check("log1", x_state, 16'h7FFE);
    @(negedge clk); check("log2", x_state, 16'h0003);
    @(negedge clk); check("log3", x_state, 16'h000B);
    @(negedge clk); check("log4", x_state, 16'h002B);
    wait_valid("first_word_latency", 4);
    check("word1_data", out_data, 8'h80);
    check("word1_x", x_state, 16'h263A);

    repeat (20) @(negedge clk);
    check("hold_x", x_state, 16'h263A);
    check("hold_data", out_data, 8'h80);
    check("hold_valid", out_valid, 1'b1);

    out_ready = 1'b1;
    wait_valid("next_word_latency", 8);
    out_ready = 1'b0;

    // Async reset with 5 bits of a partial word collected
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_x", x_state, 16'h4000);
    check("arst_valid", out_valid, 1'b0);
    check("arst_data", out_data, 8'h00);
    check("arst_cnt", reseed_cnt, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    wait_valid("arst_word_latency", 8);
    check("arst_word_data", out_data, 8'h80);
    check("arst_word_x", x_state, 16'h263A);

    // Seed load while a word is offered and accepted
    out_ready = 1'b1;
    seed_load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      seed = seed_tab[i];
      @(negedge clk);
      check("seed_x", x_state, load_tab[i]);
      check("seed_valid", out_valid, 1'b0);
      check("seed_cnt", reseed_cnt, 8'h00);
    end

    // Fixed point of the logistic map at 0x5FFF
    seed = 16'h5FFF; mode = 1'b0;
    @(negedge clk); check("guard_load", x_state, 16'h5FFF);
    seed_load = 1'b0;
    @(negedge clk);
    check("guard_x", x_state, 16'h4000);
    check("guard_cnt", reseed_cnt, 8'd1);
    for (int i = 0; i < 299; i++) begin
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      @(negedge clk);
    end
    check("guard_sat", reseed_cnt, 8'd255);

    // Tent map
    mode = 1'b1; seed = 16'h2000; seed_load = 1'b1; out_ready = 1'b0;
    @(negedge clk); check("tent_load", x_state, 16'h2000);
    seed_load = 1'b0;
    @(negedge clk); check("tent1", x_state, 16'h4000);
    @(negedge clk); check("tent2", x_state, 16'h7FFE);
    @(negedge clk); check("tent3", x_state, 16'h0002);
    wait_valid("tent_word_latency", 5);
    check("tent_word", out_data, 8'hC0);
    check("tent_word_x", x_state, 16'h0040);

    // Accept with en low, then idle, then mixed-map traffic
    en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("idle_accept_valid", out_valid, 1'b0);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_x", x_state, 16'h0040);
    en = 1'b1;
    repeat (3) @(negedge clk);
    mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 3) != 0;
      en = (i % 7) != 5;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
